// File: rtl/coeff_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : coeff_pkg                                                     |
// | Description : Shared constants, FSM state type and the Q8 preset kernel     |
// |               bank for the AXI4-Lite coefficient loader.                    |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
package coeff_pkg;

    localparam int C_NUM_COEFF   = 25;  // 5x5 kernel, row-major
    localparam int C_ADDR_STRIDE = 4;   // one 32-bit register per coefficient
    localparam int C_IDX_W       = 5;   // wide enough for index 0..24

    // Q8 fixed point: 256 represents 1.0
    localparam logic signed [15:0] C_Q8_ONE = 16'sd256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Preset bank, index = 5*row + col
    localparam logic signed [15:0] C_PRESET_TABLE [0:3][0:C_NUM_COEFF-1] = '{
        // 0: identity
        '{ 16'sd0, 16'sd0,    16'sd0,    16'sd0,    16'sd0,
           16'sd0, 16'sd0,    16'sd0,    16'sd0,    16'sd0,
           16'sd0, 16'sd0,    16'sd256,  16'sd0,    16'sd0,
           16'sd0, 16'sd0,    16'sd0,    16'sd0,    16'sd0,
           16'sd0, 16'sd0,    16'sd0,    16'sd0,    16'sd0 },
        // 1: box
        '{ 16'sd10, 16'sd10,  16'sd10,   16'sd10,   16'sd10,
           16'sd10, 16'sd10,  16'sd10,   16'sd10,   16'sd10,
           16'sd10, 16'sd10,  16'sd10,   16'sd10,   16'sd10,
           16'sd10, 16'sd10,  16'sd10,   16'sd10,   16'sd10,
           16'sd10, 16'sd10,  16'sd10,   16'sd10,   16'sd10 },
        // 2: sharpen
        '{ 16'sd0, 16'sd0,    16'sd0,    16'sd0,    16'sd0,
           16'sd0, 16'sd0,    -16'sd256, 16'sd0,    16'sd0,
           16'sd0, -16'sd256, 16'sd1280, -16'sd256, 16'sd0,
           16'sd0, 16'sd0,    -16'sd256, 16'sd0,    16'sd0,
           16'sd0, 16'sd0,    16'sd0,    16'sd0,    16'sd0 },
        // 3: edge
        '{ 16'sd0, 16'sd0,    16'sd0,    16'sd0,    16'sd0,
           16'sd0, -16'sd256, -16'sd256, -16'sd256, 16'sd0,
           16'sd0, -16'sd256, 16'sd2048, -16'sd256, 16'sd0,
           16'sd0, -16'sd256, -16'sd256, -16'sd256, 16'sd0,
           16'sd0, 16'sd0,    16'sd0,    16'sd0,    16'sd0 }
    };

endpackage
`default_nettype wire

// File: rtl/coeff_preset_rom.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : coeff_preset_rom                                              |
// | Description : Combinational lookup of one preset coefficient by (sel, idx). |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
import coeff_pkg::*;

module coeff_preset_rom (
    input  logic [1:0]          i_sel,
    input  logic [C_IDX_W-1:0]  i_idx,
    output logic signed [15:0]  o_coeff
);

    // Table lookup; indices past the last coefficient read as zero
    always_comb begin
        o_coeff = '0;
        if (i_idx < C_IDX_W'(C_NUM_COEFF)) begin
            o_coeff = C_PRESET_TABLE[i_sel][i_idx];
        end
    end

endmodule
`default_nettype wire

// File: rtl/coeff_axi_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : coeff_axi_loader                                              |
// | Description : AXI4-Lite write initiator that programs a 5x5 FIR kernel from |
// |               a built-in preset bank, one single-beat write per coefficient.|
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
import coeff_pkg::*;

module coeff_axi_loader #(
    parameter int          NUM_COEFF   = C_NUM_COEFF,
    parameter int          ADDR_STRIDE = C_ADDR_STRIDE,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_i,
    input  logic [1:0]  preset_sel_i,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [C_IDX_W-1:0]  r_idx;
    logic [1:0]          r_sel;
    logic                r_awvalid;
    logic                r_wvalid;
    logic [31:0]         r_awaddr;
    logic [31:0]         r_wdata;
    logic                r_err_acc;
    logic                r_err;

    logic                w_start_acc;
    logic                w_aw_hs;
    logic                w_w_hs;
    logic                w_b_hs;
    logic                w_issue_done;
    logic                w_last;
    logic                w_bresp_err;
    logic                w_load;
    logic [C_IDX_W-1:0]  w_load_idx;
    logic [1:0]          w_rom_sel;
    logic signed [15:0]  w_coeff;

    assign w_start_acc  = (r_state == ST_IDLE) && start_i;
    assign w_aw_hs      = r_awvalid && m_axi_awready;
    assign w_w_hs       = r_wvalid && m_axi_wready;
    assign w_b_hs       = (r_state == ST_RESP) && m_axi_bvalid;
    // Each channel is finished once its valid is gone or handshakes this cycle
    assign w_issue_done = (!r_awvalid || m_axi_awready) && (!r_wvalid || m_axi_wready);
    assign w_last       = (r_idx == C_IDX_W'(NUM_COEFF - 1));
    assign w_bresp_err  = (m_axi_bresp != 2'b00);

    // The ROM is addressed with the coefficient about to be issued, so address
    // and data are registered together on entry to ISSUE
    coeff_preset_rom u_rom (
        .i_sel   (w_rom_sel),
        .i_idx   (w_load_idx),
        .o_coeff (w_coeff)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and selection of the next coefficient to issue
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_load_idx  = '0;
        w_rom_sel   = r_sel;
        case (r_state)
            ST_IDLE: begin
                w_rom_sel = preset_sel_i;
                if (start_i) begin
                    w_state_nxt = ST_ISSUE;
                    w_load      = 1'b1;
                end
            end
            ST_ISSUE: begin
                if (w_issue_done) begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (m_axi_bvalid) begin
                    if (w_last) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt = ST_ISSUE;
                        w_load      = 1'b1;
                        w_load_idx  = r_idx + C_IDX_W'(1);
                    end
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Write channel registers: load on entry to ISSUE, drop each valid on its handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx     <= '0;
            r_sel     <= '0;
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_awaddr  <= '0;
            r_wdata   <= '0;
        end else begin
            if (w_start_acc) begin
                r_sel <= preset_sel_i;
            end
            if (w_load) begin
                r_idx     <= w_load_idx;
                r_awvalid <= 1'b1;
                r_wvalid  <= 1'b1;
                r_awaddr  <= BASE_ADDR + 32'(w_load_idx) * 32'(ADDR_STRIDE);
                r_wdata   <= {{16{w_coeff[15]}}, w_coeff};
            end else begin
                if (w_aw_hs) begin
                    r_awvalid <= 1'b0;
                end
                if (w_w_hs) begin
                    r_wvalid <= 1'b0;
                end
            end
        end
    end

    // Error accumulation; the visible flag updates only when the load completes
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err_acc <= 1'b0;
            r_err     <= 1'b0;
        end else if (w_start_acc) begin
            r_err_acc <= 1'b0;
            r_err     <= 1'b0;
        end else if (w_b_hs) begin
            r_err_acc <= r_err_acc | w_bresp_err;
            if (w_last) begin
                r_err <= r_err_acc | w_bresp_err;
            end
        end
    end

    assign busy_o        = (r_state == ST_ISSUE) || (r_state == ST_RESP);
    assign done_o        = (r_state == ST_DONE);
    assign err_o         = r_err;
    assign m_axi_awaddr  = r_awaddr;
    assign m_axi_awvalid = r_awvalid;
    assign m_axi_wdata   = r_wdata;
    assign m_axi_wstrb   = 4'hF;
    assign m_axi_wvalid  = r_wvalid;
    assign m_axi_bready  = (r_state == ST_RESP);

endmodule
`default_nettype wire

// File: tb/tb_coeff_axi_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_coeff_axi_loader                                           |
// | Description : Self-checking bench: randomized AXI4-Lite slave plus a        |
// |               reference model of the preset kernels and load timing.        |
// | Revision    : 1.0 - initial release                                         |
// +----------------------------------------------------------------------------+
module tb_coeff_axi_loader;

    logic        clk;
    logic        rst;
    logic        start_i;
    logic [1:0]  preset_sel_i;
    logic        busy_o;
    logic        done_o;
    logic        err_o;
    logic [31:0] m_axi_awaddr;
    logic        m_axi_awvalid;
    logic        m_axi_awready;
    logic [31:0] m_axi_wdata;
    logic [3:0]  m_axi_wstrb;
    logic        m_axi_wvalid;
    logic        m_axi_wready;
    logic [1:0]  m_axi_bresp;
    logic        m_axi_bvalid;
    logic        m_axi_bready;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // Slave configuration
    int aw_delay, w_delay, b_min, b_max, err_idx;
    logic [1:0] err_code;

    // Slave state and captured traffic
    int          aw_wait, w_wait, b_wait, b_delay, n_b;
    bit          aw_seen, w_seen;
    logic [31:0] aw_hold, w_hold;
    logic [31:0] aw_q[$];
    logic [31:0] w_q[$];

    logic [1:0]  exp_sel;
    int          t_start;

    coeff_axi_loader u_dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start_i),
        .preset_sel_i  (preset_sel_i),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .err_o         (err_o),
        .m_axi_awaddr  (m_axi_awaddr),
        .m_axi_awvalid (m_axi_awvalid),
        .m_axi_awready (m_axi_awready),
        .m_axi_wdata   (m_axi_wdata),
        .m_axi_wstrb   (m_axi_wstrb),
        .m_axi_wvalid  (m_axi_wvalid),
        .m_axi_wready  (m_axi_wready),
        .m_axi_bresp   (m_axi_bresp),
        .m_axi_bvalid  (m_axi_bvalid),
        .m_axi_bready  (m_axi_bready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Kernel coefficient from the geometric description of each preset
    function automatic logic [31:0] model_word(input int sel, input int k);
        int dr, dc, ar, ac, v;
        dr = k / 5 - 2;
        dc = k % 5 - 2;
        ar = (dr < 0) ? -dr : dr;
        ac = (dc < 0) ? -dc : dc;
        v  = 0;
        case (sel)
            0: v = (ar == 0 && ac == 0) ? 256 : 0;
            1: v = 10;
            2: v = (ar == 0 && ac == 0) ? 1280 : ((ar + ac == 1) ? -256 : 0);
            default: v = (ar == 0 && ac == 0) ? 2048 : ((ar <= 1 && ac <= 1) ? -256 : 0);
        endcase
        return 32'(v);
    endfunction

    task automatic set_slave(input int awd, input int wd, input int bmn, input int bmx,
                             input int ei, input logic [1:0] ec);
        aw_delay = awd;
        w_delay  = wd;
        b_min    = bmn;
        b_max    = bmx;
        err_idx  = ei;
        err_code = ec;
    endtask

    task automatic clear_slave();
        aw_q.delete();
        w_q.delete();
        n_b     = 0;
        aw_wait = 0;
        w_wait  = 0;
        b_wait  = 0;
        aw_seen = 0;
        w_seen  = 0;
        b_delay = $urandom_range(b_max, b_min);
    endtask

    // Slave: drives readies/response on the falling edge; a handshake is
    // recorded when ready is raised against a valid that holds until the rising edge
    initial begin
        m_axi_awready = 1'b0;
        m_axi_wready  = 1'b0;
        m_axi_bvalid  = 1'b0;
        m_axi_bresp   = 2'b00;
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_axi_awready = 1'b0;
                m_axi_wready  = 1'b0;
                m_axi_bvalid  = 1'b0;
                aw_seen       = 0;
                w_seen        = 0;
            end else begin
                if (m_axi_awvalid) begin
                    if (aw_seen) check("awaddr_stable", m_axi_awaddr, aw_hold);
                    aw_seen = 1;
                    aw_hold = m_axi_awaddr;
                    if (aw_wait >= aw_delay) begin
                        m_axi_awready = 1'b1;
                        check("aw_before_prev_b", aw_q.size() - n_b, 0);
                        aw_q.push_back(m_axi_awaddr);
                        aw_wait = 0;
                        aw_seen = 0;
                    end else begin
                        m_axi_awready = 1'b0;
                        aw_wait++;
                    end
                end else begin
                    m_axi_awready = 1'b0;
                    aw_seen       = 0;
                end

                if (m_axi_wvalid) begin
                    if (w_seen) check("wdata_stable", m_axi_wdata, w_hold);
                    w_seen = 1;
                    w_hold = m_axi_wdata;
                    if (w_wait >= w_delay) begin
                        m_axi_wready = 1'b1;
                        check("wstrb", m_axi_wstrb, 32'hF);
                        w_q.push_back(m_axi_wdata);
                        w_wait = 0;
                        w_seen = 0;
                    end else begin
                        m_axi_wready = 1'b0;
                        w_wait++;
                    end
                end else begin
                    m_axi_wready = 1'b0;
                    w_seen       = 0;
                end

                if (m_axi_bready && aw_q.size() > n_b && w_q.size() > n_b) begin
                    if (b_wait >= b_delay) begin
                        m_axi_bvalid = 1'b1;
                        m_axi_bresp  = (n_b == err_idx) ? err_code : 2'b00;
                        n_b++;
                        b_wait  = 0;
                        b_delay = $urandom_range(b_max, b_min);
                    end else begin
                        m_axi_bvalid = 1'b0;
                        b_wait++;
                    end
                end else begin
                    m_axi_bvalid = 1'b0;
                end
            end
        end
    end

    // Pulse start for one cycle; cyc at this falling edge is cycle t-1
    task automatic do_start(input logic [1:0] sel);
        @(negedge clk);
        clear_slave();
        exp_sel      = sel;
        start_i      = 1'b1;
        preset_sel_i = sel;
        t_start      = cyc;
        @(negedge clk);
        start_i      = 1'b0;
        preset_sel_i = ~sel;
        check("busy_after_start", busy_o, 1);
        check("err_cleared_on_start", err_o, 0);
    endtask

    task automatic finish_load(input int restart_at, input logic exp_err, input int exp_lat);
        int  dones;
        bit  got;
        bit  pulsed;
        dones  = 0;
        got    = 0;
        pulsed = 0;
        for (int i = 0; i < 3000 && !got; i++) begin
            @(negedge clk);
            if (restart_at >= 0 && !pulsed && n_b == restart_at) begin
                start_i      = 1'b1;
                preset_sel_i = exp_sel ^ 2'b01;
                pulsed       = 1;
            end else begin
                start_i = 1'b0;
            end
            if (done_o) begin
                got = 1;
                dones++;
                check("busy_at_done", busy_o, 0);
                check("err_at_done", err_o, exp_err);
                if (exp_lat >= 0) check("done_latency", cyc - t_start, exp_lat);
            end
        end
        if (!got) check("done_timeout", 0, 1);
        start_i = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (done_o) dones++;
        end
        check("done_pulses", dones, 1);
        check("err_held", err_o, exp_err);
        check("busy_idle", busy_o, 0);
        check("aw_count", aw_q.size(), 25);
        check("w_count", w_q.size(), 25);
        check("b_count", n_b, 25);
        for (int k = 0; k < 25 && k < aw_q.size(); k++)
            check($sformatf("awaddr[%0d]", k), aw_q[k], 32'(4 * k));
        for (int k = 0; k < 25 && k < w_q.size(); k++)
            check($sformatf("wdata[%0d]", k), w_q[k], model_word(exp_sel, k));
    endtask

    initial begin
        bit hit;
        int dn;
        int e;
        rst          = 1'b0;
        start_i      = 1'b0;
        preset_sel_i = 2'd0;
        set_slave(0, 0, 0, 0, -1, 2'b10);
        clear_slave();

        repeat (2) @(negedge clk);
        check("rst_awvalid", m_axi_awvalid, 0);
        check("rst_wvalid", m_axi_wvalid, 0);
        check("rst_bready", m_axi_bready, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", err_o, 0);
        check("rst_awaddr", m_axi_awaddr, 0);
        check("rst_wdata", m_axi_wdata, 0);
        rst = 1'b1;

        // Identity, slave always ready: best-case timing
        set_slave(0, 0, 0, 0, -1, 2'b10);
        do_start(2'd0);
        finish_load(-1, 1'b0, 51);

        // Sharpen, address channel stalled 3 cycles
        set_slave(3, 0, 0, 0, -1, 2'b10);
        do_start(2'd2);
        finish_load(-1, 1'b0, -1);

        // Edge, random response latency 0..5
        set_slave(0, 0, 0, 5, -1, 2'b10);
        do_start(2'd3);
        finish_load(-1, 1'b0, -1);

        // SLVERR on write 7 only
        set_slave(0, 0, 0, 0, 7, 2'b10);
        do_start(2'd1);
        finish_load(-1, 1'b1, 51);

        // Next start clears the error
        set_slave(0, 0, 0, 0, -1, 2'b10);
        do_start(2'd0);
        finish_load(-1, 1'b0, 51);

        // Start re-pulsed with another preset at index 10 is ignored
        set_slave(0, 0, 0, 0, -1, 2'b10);
        do_start(2'd2);
        finish_load(10, 1'b0, 51);

        // Reset while waiting for the response of write 12
        set_slave(0, 0, 4, 4, -1, 2'b10);
        do_start(2'd3);
        hit = 0;
        for (int i = 0; i < 500 && !hit; i++) begin
            @(negedge clk);
            if (m_axi_bready && n_b == 12) hit = 1;
        end
        check("reach_resp_idx12", hit, 1);
        #2 rst = 1'b0;
        #1;
        check("arst_awvalid", m_axi_awvalid, 0);
        check("arst_wvalid", m_axi_wvalid, 0);
        check("arst_bready", m_axi_bready, 0);
        check("arst_busy", busy_o, 0);
        dn = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_o) dn++;
        end
        rst = 1'b1;
        repeat (2) begin
            @(negedge clk);
            if (done_o) dn++;
        end
        check("no_done_after_reset", dn, 0);
        set_slave(0, 0, 0, 0, -1, 2'b10);
        do_start(2'd2);
        finish_load(-1, 1'b0, 51);

        // Randomized loads, including EXOKAY/SLVERR/DECERR responses
        for (int r = 0; r < 6; r++) begin
            e = ($urandom_range(1, 0) == 1) ? int'($urandom_range(24, 0)) : -1;
            set_slave($urandom_range(3, 0), $urandom_range(3, 0), 0, $urandom_range(4, 0),
                      e, 2'($urandom_range(3, 1)));
            do_start(2'($urandom_range(3, 0)));
            finish_load(-1, (e >= 0), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/coeff_axi_loader.md
Name: coeff_axi_loader

Overview:
- AXI4-Lite write initiator that programs the 25 signed 5x5 kernel coefficients of the FIR filter's coefficient write port from a built-in preset bank.
- Sits between control logic (button/switch or MicroBlaze GPIO pulse) and the filter_axi_* write channels; the filter needs no CPU software to change kernels.
- Issues one single-beat write per coefficient, row-major, and reports done and error.

Parameters:
- NUM_COEFF, 25, coefficients per kernel (5x5); fixed, no other value supported
- ADDR_STRIDE, 4, byte stride between coefficient registers
- BASE_ADDR, 32'h0000_0000, byte address of coeff00

Ports:
- clk  in  1  system clock (MicroBlaze/AXI clock domain)
- rst  in  1  asynchronous, active-low reset
- start_i  in  1  single-cycle request to load a preset
- preset_sel_i  in  2  preset index; sampled only with an accepted start_i
- busy_o  out  1  high while a load is in progress
- done_o  out  1  one-cycle pulse after the last write response
- err_o  out  1  at done_o: at least one write returned bresp != OKAY; holds until next accepted start
- m_axi_awaddr  out  32  write address
- m_axi_awvalid  out  1
- m_axi_awready  in  1
- m_axi_wdata  out  32  coefficient, sign-extended from 16 bits
- m_axi_wstrb  out  4  always 4'hF
- m_axi_wvalid  out  1
- m_axi_wready  in  1
- m_axi_bresp  in  2
- m_axi_bvalid  in  1
- m_axi_bready  out  1

Behaviour:
- Reset (rst low, async): state IDLE, idx=0, awvalid=wvalid=bready=0, busy_o=0, done_o=0, err_o=0, awaddr=0, wdata=0.
- FSM states: IDLE, ISSUE, RESP, DONE.
- IDLE: start_i=1 at edge t -> latch preset_sel, clear err, idx=0, go ISSUE. busy_o high from t+1.
- ISSUE: awvalid and wvalid both rise on entry. awaddr = BASE_ADDR + idx*ADDR_STRIDE. wdata = sign-extended preset[sel][idx].
- ISSUE handshakes: each valid drops independently on its own handshake (valid & ready). Address and data stay stable while their valid is high. Valids never depend on ready.
- ISSUE exit: when both handshakes are complete (same cycle or different cycles), go RESP.
- RESP: bready=1. On bvalid: OR (bresp != 2'b00) into err. If idx==24 go DONE, else idx+1 and go ISSUE.
- Minimum throughput: 2 cycles per coefficient (ISSUE with immediate ready, RESP with immediate bvalid).
- DONE: done_o=1 for exactly one cycle, busy_o drops with done_o, next state IDLE.
- Best-case load: start at t, done_o at t+51.
- Index mapping: idx = 5*row + col. coeffRC at byte 4*idx, coeff00 = 0x00, coeff44 = 0x60.
- start_i while busy: ignored; preset_sel not resampled.
- An error does not abort the load; all 25 writes always complete. EXOKAY (01) counts as error.
- bvalid arriving in ISSUE is not possible with a compliant slave; if it occurs, it is ignored (bready=0 there).
- Reset mid-load: outputs drop immediately, no done_o. The slave must be reset in the same domain or it may hold a stale response.
- Preset bank (Q8, 256 = 1.0), all unlisted entries 0:
  - 0 identity: c22=256.
  - 1 box: all 25 = 10.
  - 2 sharpen: c22=1280; c12, c21, c23, c32 = -256.
  - 3 edge: c22=2048; the 8 neighbours of c22 = -256.

Decomposition:
- Shared package coeff_pkg: NUM_COEFF, ADDR_STRIDE, the Q8 scale constant, the 4x25 preset table as signed 16-bit constants, and a state enum localparam set.
- One sub-module, coeff_preset_rom: combinational lookup (sel, idx) -> signed 16-bit coefficient. The FSM stays in coeff_axi_loader.

Test Plan:
- Preset 0, slave always ready, bresp=OKAY -> 25 writes at awaddr 0x00..0x60 step 4. Data at 0x30 = 0x0000_0100, all other data 0. done_o at t+51, err_o=0.
- Preset 2, awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle. awvalid/awaddr stay stable until the handshake. Data at 0x2C = 0xFFFF_FF00, at 0x30 = 0x0000_0500.
- Preset 3, bvalid delayed randomly 0-5 cycles -> exactly 25 B-handshakes. No new awvalid before the previous bvalid. Data at 0x18 = 0xFFFF_FF00.
- bresp=SLVERR (2'b10) on write idx 7 only -> all 25 writes still issued, err_o=1 at done_o and held. Next start clears err_o.
- start_i pulsed again at idx 10 with a different preset_sel -> ignored, original preset completes, single done_o.
- rst low during RESP at idx 12 -> awvalid, wvalid, bready, busy_o all 0 asynchronously. No done_o. After release, a fresh start completes normally.
